spi_cfg_slave_bridge: RTL and testbench

- Parametrised, oversampled SPI slave with an integrated register file and a committed-write config channel.
- Successor to the fixed 8-bit, 6-register SPI slave/register-file pair.
- Adds SPI mode selection (CPOL/CPHA), configurable address and data width, burst transfers with address auto-increment, and a valid/ready config stream with overflow detection.
- Sits between the external SPI pads and on-chip configuration consumers; everything runs in sys_clk_i.

---
 rtl/spi_cfg_slave_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_spi_cfg_slave_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_slave_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_cfg_slave_bridge
// Brief   : Oversampled SPI slave with register file and committed-write
//           config stream (one-entry holding register, sticky overflow).
// Rev     : 1.0
// ============================================================================
module spi_cfg_slave_bridge #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic                         sys_clk_i,
    input  logic                         sys_rst_i,
    input  logic                         spi_csb_i,
    input  logic                         spi_sclk_i,
    input  logic                         spi_mosi_i,
    output logic                         spi_miso_o,
    output logic                         spi_miso_oe_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         cfg_valid_o,
    input  logic                         cfg_ready_i,
    output logic [ADDR_W-1:0]            cfg_addr_o,
    output logic [DATA_W-1:0]            cfg_data_o,
    output logic                         frame_err_o
);

    localparam int c_cmd_w = 1 + ADDR_W;
    localparam int c_rx_w  = (c_cmd_w > DATA_W) ? c_cmd_w : DATA_W;
    localparam int c_cnt_w = $clog2(c_rx_w);
    localparam logic [ADDR_W-1:0] c_status   = ADDR_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NUM_REGS - 1);
    localparam bit c_sample_rise = (CPOL == CPHA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    // Synchronisers are deliberately not reset so that a frame already in
    // progress when reset releases does not look like a fresh CSB fall.
    logic [1:0] r_csb_s, r_sclk_s, r_mosi_s;
    logic       r_csb_d, r_sclk_d, r_mosi_d;

    always_ff @(posedge sys_clk_i) begin
        r_csb_s  <= {r_csb_s[0], spi_csb_i};
        r_sclk_s <= {r_sclk_s[0], spi_sclk_i};
        r_mosi_s <= {r_mosi_s[0], spi_mosi_i};
        r_csb_d  <= r_csb_s[1];
        r_sclk_d <= r_sclk_s[1];
        r_mosi_d <= r_mosi_s[1];
    end

    logic w_csb_fall, w_csb_rise, w_sample, w_shift;
    assign w_csb_fall = ~r_csb_s[1] &  r_csb_d;
    assign w_csb_rise =  r_csb_s[1] & ~r_csb_d;
    assign w_sample   = c_sample_rise ? (r_sclk_s[1] & ~r_sclk_d) : (~r_sclk_s[1] & r_sclk_d);
    assign w_shift    = c_sample_rise ? (~r_sclk_s[1] & r_sclk_d) : (r_sclk_s[1] & ~r_sclk_d);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_rx_w-2:0]   r_rx;
    logic [DATA_W-1:0]   r_tx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic                r_miso, r_oe, r_frame_err;
    logic                r_post;
    logic [ADDR_W-1:0]   r_post_addr;
    logic [DATA_W-1:0]   r_post_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_cfg_valid, r_overflow;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_data;

    logic [c_rx_w-1:0]   w_rx_next;
    logic [DATA_W-1:0]   w_rx_data, w_rd_word;
    logic [ADDR_W-1:0]   w_addr_inc, w_load_addr;
    logic                w_cmd_last, w_data_last, w_word_done, w_stat_clr, w_in_range;

    assign w_rx_next   = {r_rx, r_mosi_d};
    assign w_rx_data   = w_rx_next[DATA_W-1:0];
    assign w_cmd_last  = (r_bit_cnt == c_cnt_w'(c_cmd_w - 1));
    assign w_data_last = (r_bit_cnt == c_cnt_w'(DATA_W - 1));
    assign w_addr_inc  = (r_addr == c_last_reg) ? '0 : r_addr + 1'b1;
    assign w_load_addr = (r_state == S_CMD) ? w_rx_next[ADDR_W-1:0] : w_addr_inc;
    assign w_in_range  = (r_addr < c_status);
    assign w_word_done = (r_state == S_DATA) && w_sample && w_data_last && !w_csb_rise;
    assign w_stat_clr  = w_word_done && !r_write && (r_addr == c_status);

    // Read word for whichever address is about to become current.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_load_addr == ADDR_W'(k)) w_rd_word = r_regs[k];
        end
        if (w_load_addr == c_status) w_rd_word = {{(DATA_W-1){1'b0}}, r_overflow};
    end

    always_ff @(posedge sys_clk_i) begin
        r_frame_err <= 1'b0;
        r_post      <= 1'b0;
        if (sys_rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_post_addr <= '0;
            r_post_data <= '0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (w_csb_rise) begin
            r_frame_err <= (r_state != S_IDLE) && (r_bit_cnt != '0);
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_csb_fall) begin
                        r_state   <= S_CMD;
                        r_bit_cnt <= '0;
                        r_miso    <= 1'b0;
                        r_oe      <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (w_sample) begin
                        r_rx <= w_rx_next[c_rx_w-2:0];
                        if (w_cmd_last) begin
                            r_bit_cnt <= '0;
                            r_write   <= w_rx_next[c_cmd_w-1];
                            r_addr    <= w_rx_next[ADDR_W-1:0];
                            r_tx      <= w_rd_word;
                            r_state   <= S_DATA;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_shift) begin
                        r_miso <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_rx <= w_rx_next[c_rx_w-2:0];
                        if (w_data_last) begin
                            r_bit_cnt <= '0;
                            if (r_write) begin
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (r_addr == ADDR_W'(k)) r_regs[k] <= w_rx_data;
                                end
                                r_post      <= w_in_range;
                                r_post_addr <= r_addr;
                                r_post_data <= w_rx_data;
                            end
                            r_addr <= w_addr_inc;
                            r_tx   <= w_rd_word;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_shift) begin
                        r_miso <= r_tx[DATA_W-1];
                        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A newer post always wins the holding register; losing an unaccepted
    // entry is what the sticky overflow flag records.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_cfg_valid <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_stat_clr) r_overflow <= 1'b0;
            if (r_post) begin
                if (r_cfg_valid && !cfg_ready_i) r_overflow <= 1'b1;
                r_cfg_valid <= 1'b1;
                r_cfg_addr  <= r_post_addr;
                r_cfg_data  <= r_post_data;
            end else if (r_cfg_valid && cfg_ready_i) begin
                r_cfg_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = r_oe;
    assign cfg_valid_o   = r_cfg_valid;
    assign cfg_addr_o    = r_cfg_addr;
    assign cfg_data_o    = r_cfg_data;
    assign frame_err_o   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_slave_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_spi_cfg_slave_bridge
// Brief   : Scoreboard bench driving three bridge instances (modes 0, 1, 3).
// Rev     : 1.0
// ============================================================================
module tb_spi_cfg_slave_bridge;

    localparam int HALF = 80;

    typedef struct {
        int         inst;
        logic [6:0] addr;
        logic [7:0] data;
    } cfg_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         csb [3];
    logic         sclk [3];
    logic         mosi [3];
    logic         miso [3];
    logic         oe [3];
    logic         cfg_valid [3];
    logic         cfg_ready [3];
    logic         ferr [3];
    logic [6:0]   cfg_addr [3];
    logic [7:0]   cfg_data [3];
    logic [127:0] regs [3];

    int           n_cmp = 0;
    int           n_err = 0;
    int           ferr_cnt [3] = '{0, 0, 0};
    cfg_t         cfg_q [$];
    logic [7:0]   rd_q [$];
    string        rd_name_q [$];
    logic [7:0]   rd_obs;
    event         rd_ev;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_cfg_slave_bridge #(
            .ADDR_W(7), .DATA_W(8), .NUM_REGS(16),
            .CPOL((g == 2) ? 1 : 0), .CPHA((g == 0) ? 0 : 1)
        ) u_dut (
            .sys_clk_i    (clk),
            .sys_rst_i    (rst),
            .spi_csb_i    (csb[g]),
            .spi_sclk_i   (sclk[g]),
            .spi_mosi_i   (mosi[g]),
            .spi_miso_o   (miso[g]),
            .spi_miso_oe_o(oe[g]),
            .regs_o       (regs[g]),
            .cfg_valid_o  (cfg_valid[g]),
            .cfg_ready_i  (cfg_ready[g]),
            .cfg_addr_o   (cfg_addr[g]),
            .cfg_data_o   (cfg_data[g]),
            .frame_err_o  (ferr[g])
        );
    end

    function automatic logic cpol_of(input int m);
        return (m == 2);
    endfunction

    function automatic logic cpha_of(input int m);
        return (m != 0);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic csb_low(input int m);
        csb[m] = 1'b0;
        #HALF;
    endtask

    task automatic csb_high(input int m);
        #HALF;
        csb[m] = 1'b1;
        #(2 * HALF);
    endtask

    task automatic xfer(input int m, input logic [7:0] val, input int nbits, output logic [7:0] rxv);
        rxv = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_of(m)) begin
                mosi[m] = val[7-i];
                #HALF;
                sclk[m] = ~cpol_of(m);
                rxv = {rxv[6:0], miso[m]};
                #HALF;
                sclk[m] = cpol_of(m);
            end else begin
                sclk[m] = ~cpol_of(m);
                mosi[m] = val[7-i];
                #HALF;
                sclk[m] = cpol_of(m);
                rxv = {rxv[6:0], miso[m]};
                #HALF;
            end
        end
    endtask

    task automatic write_frame(input int m, input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] rx;
        csb_low(m);
        xfer(m, cmd, 8, rx);
        xfer(m, data, 8, rx);
        csb_high(m);
    endtask

    // Shifts one byte and hands the captured MISO byte to the read monitor.
    task automatic read_word(input int m, input logic [7:0] tx, input logic [7:0] exp, input string name);
        logic [7:0] rx;
        rd_q.push_back(exp);
        rd_name_q.push_back(name);
        xfer(m, tx, 8, rx);
        rd_obs = rx;
        ->rd_ev;
    endtask

    task automatic set_ready(input int m, input logic v);
        @(posedge clk);
        #1;
        cfg_ready[m] = v;
    endtask

    // Config-stream monitor: every accepted transfer must match the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cfg_valid[i] === 1'b1 && cfg_ready[i] === 1'b1) begin
                n_cmp++;
                if (cfg_q.size() == 0) begin
                    n_err++;
                    $display("FAIL cfg_unexpected: inst %0d got addr %0h data %0h required no transfer",
                             i, cfg_addr[i], cfg_data[i]);
                end else begin
                    cfg_t e;
                    e = cfg_q.pop_front();
                    if (e.inst != i || e.addr !== cfg_addr[i] || e.data !== cfg_data[i]) begin
                        n_err++;
                        $display("FAIL cfg_xfer: got inst %0d addr %0h data %0h required inst %0d addr %0h data %0h",
                                 i, cfg_addr[i], cfg_data[i], e.inst, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(rd_ev);
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %0h required none", rd_obs);
            end else begin
                logic [7:0] e;
                string nm;
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                if (rd_obs !== e) begin
                    n_err++;
                    $display("FAIL %s: got %0h required %0h", nm, rd_obs, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ferr[i] === 1'b1) ferr_cnt[i]++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit hit, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        int         base;

        for (int m = 0; m < 3; m++) begin
            csb[m]       = 1'b1;
            sclk[m]      = cpol_of(m);
            mosi[m]      = 1'b0;
            cfg_ready[m] = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("rst_regs", regs[0], '0);
        check("rst_valid", cfg_valid[0], 1'b0);
        check("rst_oe", oe[0], 1'b0);
        check("rst_miso", miso[0], 1'b0);
        check("rst_ferr", ferr[0], 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Mode 0 single write, held until the consumer accepts.
        cfg_q.push_back('{inst: 0, addr: 7'd3, data: 8'hA5});
        write_frame(0, 8'h83, 8'hA5);
        check("t1_reg3", regs[0][31:24], 8'hA5);
        check("t1_valid", cfg_valid[0], 1'b1);
        check("t1_addr", cfg_addr[0], 7'd3);
        check("t1_data", cfg_data[0], 8'hA5);
        repeat (5) @(posedge clk);
        #1;
        check("t1_hold", cfg_valid[0], 1'b1);
        set_ready(0, 1'b1);
        @(posedge clk);
        #1;
        check("t1_drop", cfg_valid[0], 1'b0);

        // Mode 3 burst write wrapping past the last register.
        set_ready(2, 1'b1);
        cfg_q.push_back('{inst: 2, addr: 7'd14, data: 8'h11});
        cfg_q.push_back('{inst: 2, addr: 7'd15, data: 8'h22});
        cfg_q.push_back('{inst: 2, addr: 7'd0,  data: 8'h33});
        csb_low(2);
        xfer(2, 8'h8E, 8, rx);
        xfer(2, 8'h11, 8, rx);
        xfer(2, 8'h22, 8, rx);
        xfer(2, 8'h33, 8, rx);
        csb_high(2);
        check("t2_reg14", regs[2][119:112], 8'h11);
        check("t2_reg15", regs[2][127:120], 8'h22);
        check("t2_reg0", regs[2][7:0], 8'h33);

        // Mode 1 preload then burst read.
        set_ready(1, 1'b1);
        cfg_q.push_back('{inst: 1, addr: 7'd5, data: 8'h3C});
        cfg_q.push_back('{inst: 1, addr: 7'd6, data: 8'h5A});
        csb_low(1);
        xfer(1, 8'h85, 8, rx);
        xfer(1, 8'h3C, 8, rx);
        xfer(1, 8'h5A, 8, rx);
        csb_high(1);
        check("t3_oe_idle", oe[1], 1'b0);
        csb_low(1);
        check("t3_oe_active", oe[1], 1'b1);
        read_word(1, 8'h05, 8'h00, "t3_miso_cmd");
        read_word(1, 8'h00, 8'h3C, "t3_rd_reg5");
        read_word(1, 8'h00, 8'h5A, "t3_rd_reg6");
        csb_high(1);
        check("t3_oe_after", oe[1], 1'b0);

        // Overflow: two unaccepted writes, then status read clears it.
        set_ready(0, 1'b0);
        write_frame(0, 8'h82, 8'h01);
        write_frame(0, 8'h82, 8'h02);
        check("t4_valid", cfg_valid[0], 1'b1);
        check("t4_data", cfg_data[0], 8'h02);
        cfg_q.push_back('{inst: 0, addr: 7'd2, data: 8'h02});
        set_ready(0, 1'b1);
        csb_low(0);
        xfer(0, 8'h10, 8, rx);
        read_word(0, 8'h00, 8'h01, "t4_status_ovf");
        csb_high(0);
        csb_low(0);
        xfer(0, 8'h10, 8, rx);
        read_word(0, 8'h00, 8'h00, "t4_status_clr");
        csb_high(0);

        // Frame error: CSB rises after 5 data bits.
        base = ferr_cnt[0];
        csb_low(0);
        xfer(0, 8'h84, 8, rx);
        xfer(0, 8'hFF, 5, rx);
        csb_high(0);
        check("t5_ferr_once", ferr_cnt[0] - base, 1);
        check("t5_reg4", regs[0][39:32], 8'h00);
        check("t5_no_valid", cfg_valid[0], 1'b0);
        cfg_q.push_back('{inst: 0, addr: 7'd4, data: 8'h77});
        write_frame(0, 8'h84, 8'h77);
        check("t5_next_reg4", regs[0][39:32], 8'h77);
        check("t5_ferr_stable", ferr_cnt[0] - base, 1);

        // Reset mid-word, remainder of the frame must be ignored.
        base = ferr_cnt[0];
        csb_low(0);
        xfer(0, 8'h86, 8, rx);
        xfer(0, 8'hC3, 3, rx);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_regs", regs[0], '0);
        check("t6_rst_valid", cfg_valid[0], 1'b0);
        check("t6_rst_addr", cfg_addr[0], 7'd0);
        check("t6_rst_data", cfg_data[0], 8'h00);
        check("t6_rst_oe", oe[0], 1'b0);
        check("t6_rst_miso", miso[0], 1'b0);
        rst = 1'b0;
        xfer(0, 8'h18, 5, rx);
        xfer(0, 8'hFF, 8, rx);
        check("t6_oe_ignored", oe[0], 1'b0);
        csb_high(0);
        check("t6_regs_ignored", regs[0], '0);
        check("t6_no_ferr", ferr_cnt[0] - base, 0);
        cfg_q.push_back('{inst: 0, addr: 7'd6, data: 8'h5E});
        write_frame(0, 8'h86, 8'h5E);
        check("t6_reg6", regs[0], 128'h5E << 48);
        write_frame(0, 8'hA0, 8'h99);
        check("t6_oor_regs", regs[0], 128'h5E << 48);
        check("t6_oor_valid", cfg_valid[0], 1'b0);

        for (int i = 0; i < 200 && (cfg_q.size() != 0 || rd_q.size() != 0); i++) @(posedge clk);
        check("drain_cfg_q", cfg_q.size(), 0);
        check("drain_rd_q", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
